// File: rtl/alu_if.sv
// Operand/result bundle between the ALU and whatever drives it.
// The driver (master) owns operands and opcode; the ALU (slave) owns the registered results.
interface alu_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;

  modport master (
    output A,
    output B,
    output ALU_Sel,
    input  ALU_Out,
    input  CarryOut
  );

  modport slave (
    input  A,
    input  B,
    input  ALU_Sel,
    output ALU_Out,
    output CarryOut
  );
endinterface

// File: rtl/alu.sv
// Parameterised ALU: 16 unsigned operations, result and sum-carry registered one cycle later.
// Synchronous active-high reset clears both outputs.
module alu #(
  parameter int WIDTH = 8
) (
  input logic   clk,
  input logic   rst,
  alu_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] result;

  // Carry always comes from A+B, whatever the opcode.
  assign sum_ext = {1'b0, bus.A} + {1'b0, bus.B};

  always_comb begin
    result = '0;
    case (bus.ALU_Sel)
      OP_ADD:  result = sum_ext[WIDTH-1:0];
      OP_SUB:  result = bus.A - bus.B;
      OP_MUL:  result = bus.A * bus.B;
      OP_DIV:  result = (bus.B == '0) ? '0 : (bus.A / bus.B);
      OP_SHL:  result = {bus.A[WIDTH-2:0], 1'b0};
      OP_SHR:  result = {1'b0, bus.A[WIDTH-1:1]};
      OP_ROL:  result = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
      OP_ROR:  result = {bus.A[0], bus.A[WIDTH-1:1]};
      OP_AND:  result = bus.A & bus.B;
      OP_OR:   result = bus.A | bus.B;
      OP_XOR:  result = bus.A ^ bus.B;
      OP_NOR:  result = ~(bus.A | bus.B);
      OP_NAND: result = ~(bus.A & bus.B);
      OP_XNOR: result = ~(bus.A ^ bus.B);
      OP_GT:   result = {{(WIDTH-1){1'b0}}, (bus.A > bus.B)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (bus.A == bus.B)};
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ALU_Out  <= '0;
      bus.CarryOut <= 1'b0;
    end else begin
      bus.ALU_Out  <= result;
      bus.CarryOut <= sum_ext[WIDTH];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequence, and a
// back-to-back opcode sweep with a mid-stream reset against an arithmetic model.
module tb_alu;

  logic clk;
  logic rst;

  alu_if #(.WIDTH(8)) bus ();

  alu #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       carry;
  } vec_t;

  vec_t vecs[$];

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  // Independent model built from integer arithmetic rather than bit slicing.
  task automatic model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] o, output logic c);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    c  = (ia + ib) > 255;
    case (s)
      4'd0:  r = (ia + ib) % 256;
      4'd1:  r = (ia - ib + 256) % 256;
      4'd2:  r = (ia * ib) % 256;
      4'd3:  r = (ib == 0) ? 0 : ia / ib;
      4'd4:  r = (ia * 2) % 256;
      4'd5:  r = ia / 2;
      4'd6:  r = ((ia * 2) % 256) + ia / 128;
      4'd7:  r = ia / 2 + (ia % 2) * 128;
      4'd8:  r = int'(a & b);
      4'd9:  r = int'(a | b);
      4'd10: r = int'(a ^ b);
      4'd11: r = 255 - int'(a | b);
      4'd12: r = 255 - int'(a & b);
      4'd13: r = 255 - int'(a ^ b);
      4'd14: r = (ia > ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    o = r[7:0];
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.ALU_Sel = s;
    bus.A       = a;
    bus.B       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_o;
    logic       exp_c;
    logic [3:0] s;
    logic [7:0] ra, rb;

    vecs.push_back('{"rol_81",     4'b0110, 8'h81, 8'h00, 8'h03, 1'b0});
    vecs.push_back('{"rol_ff",     4'b0110, 8'hFF, 8'h00, 8'hFF, 1'b0});
    vecs.push_back('{"rol_00",     4'b0110, 8'h00, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{"rol_carry",  4'b0110, 8'h81, 8'h80, 8'h03, 1'b1});
    vecs.push_back('{"sub_wrap",   4'b0001, 8'h05, 8'h07, 8'hFE, 1'b0});
    vecs.push_back('{"mul_wrap",   4'b0010, 8'h10, 8'h20, 8'h00, 1'b0});
    vecs.push_back('{"div",        4'b0011, 8'd100, 8'd7, 8'd14, 1'b0});
    vecs.push_back('{"div_zero",   4'b0011, 8'h55, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{"shr_81",     4'b0101, 8'h81, 8'h00, 8'h40, 1'b0});
    vecs.push_back('{"ror_81",     4'b0111, 8'h81, 8'h00, 8'hC0, 1'b0});
    vecs.push_back('{"shl_81",     4'b0100, 8'h81, 8'h00, 8'h02, 1'b0});
    vecs.push_back('{"and",        4'b1000, 8'hF0, 8'h3C, 8'h30, 1'b1});
    vecs.push_back('{"or",         4'b1001, 8'hF0, 8'h3C, 8'hFC, 1'b1});
    vecs.push_back('{"xor",        4'b1010, 8'hF0, 8'h3C, 8'hCC, 1'b1});
    vecs.push_back('{"nor",        4'b1011, 8'hF0, 8'h3C, 8'h03, 1'b1});
    vecs.push_back('{"nand",       4'b1100, 8'hF0, 8'h3C, 8'hCF, 1'b1});
    vecs.push_back('{"xnor",       4'b1101, 8'hF0, 8'h3C, 8'h33, 1'b1});
    vecs.push_back('{"gt_true",    4'b1110, 8'hF0, 8'h3C, 8'h01, 1'b1});
    vecs.push_back('{"eq_false",   4'b1111, 8'hF0, 8'h3C, 8'h00, 1'b1});
    vecs.push_back('{"eq_true",    4'b1111, 8'h3C, 8'h3C, 8'h01, 1'b0});
    vecs.push_back('{"gt_equal",   4'b1110, 8'h3C, 8'h3C, 8'h00, 1'b0});
    vecs.push_back('{"add_wrap",   4'b0000, 8'h80, 8'h80, 8'h00, 1'b1});
    vecs.push_back('{"add",        4'b0000, 8'h12, 8'h34, 8'h46, 1'b0});

    // Reset held for two edges with inputs that would otherwise give FE/carry.
    rst         = 1'b1;
    bus.A       = 8'hFF;
    bus.B       = 8'hFF;
    bus.ALU_Sel = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check8("reset_out", bus.ALU_Out, 8'h00);
      check1("reset_carry", bus.CarryOut, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check8("post_reset_out", bus.ALU_Out, 8'hFE);
    check1("post_reset_carry", bus.CarryOut, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].a, vecs[i].b);
      check8({vecs[i].name, "_out"}, bus.ALU_Out, vecs[i].out);
      check1({vecs[i].name, "_carry"}, bus.CarryOut, vecs[i].carry);
    end

    // Held inputs: outputs stay put over several edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check8("hold_out", bus.ALU_Out, 8'h46);
    end

    // Back-to-back sweep of all opcodes, twice, with a one-cycle reset between passes.
    for (int pass = 0; pass < 2; pass++) begin
      for (int op = 0; op < 16; op++) begin
        s  = op[3:0];
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        if (op == 3 && pass == 1) rb = 8'h00;
        drive(s, ra, rb);
        model(s, ra, rb, exp_o, exp_c);
        check8($sformatf("pipe_p%0d_op%0d_out", pass, op), bus.ALU_Out, exp_o);
        check1($sformatf("pipe_p%0d_op%0d_carry", pass, op), bus.CarryOut, exp_c);
      end
      if (pass == 0) begin
        @(negedge clk);
        rst         = 1'b1;
        bus.ALU_Sel = 4'b0000;
        bus.A       = 8'hC3;
        bus.B       = 8'hC3;
        @(posedge clk);
        #1;
        check8("mid_reset_out", bus.ALU_Out, 8'h00);
        check1("mid_reset_carry", bus.CarryOut, 1'b0);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Parameterised 8-bit arithmetic/logic unit with a registered result. On each clock edge it samples two operands and a 4-bit operation select, then presents the 8-bit result and a carry flag one cycle later. It is the datapath block driven by the verification environment's `intf` operand/result bundle, and it is clocked from the shared `clk_if` clock.

## Interface
- `WIDTH`, default 8: operand and result width. Opcode semantics below assume WIDTH ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `A`  in  WIDTH  operand A, unsigned.
- `B`  in  WIDTH  operand B, unsigned.
- `ALU_Sel`  in  4  operation select.
- `ALU_Out`  out  WIDTH  registered operation result.
- `CarryOut`  out  1  registered carry out of the unsigned sum A+B.

## Operation
Results are unsigned and truncated to WIDTH bits.

`ALU_Sel` opcodes:
- 0000: A + B.
- 0001: A − B, modulo 2^WIDTH.
- 0010: A × B, low WIDTH bits.
- 0011: A / B, integer quotient. If B = 0, the result is all-zeros.
- 0100: A << 1, with zero fill.
- 0101: A >> 1, with zero fill.
- 0110: rotate A left by 1; the MSB moves to bit 0.
- 0111: rotate A right by 1; bit 0 moves to the MSB.
- 1000: A & B.
- 1001: A | B.
- 1010: A ^ B.
- 1011: ~(A | B).
- 1100: ~(A & B).
- 1101: ~(A ^ B).
- 1110: 1 if A > B (unsigned), else 0; zero-extended to WIDTH.
- 1111: 1 if A == B, else 0; zero-extended to WIDTH.

`CarryOut`:
- Equals bit WIDTH of the (WIDTH+1)-bit sum {0,A}+{0,B}.
- It is computed this way for every opcode, independent of `ALU_Sel`.

Internal structure and constraints:
- The combinational result and carry feed output registers.
- There are no other state elements.
- There is no handshake. A new operation is accepted every cycle.

## Timing
- Reset: when `rst` = 1 at a rising edge, `ALU_Out` ← 0 and `CarryOut` ← 0. These values hold while `rst` stays high. Inputs are ignored during reset.
- Latency: the inputs sampled at edge n appear on `ALU_Out`/`CarryOut` after edge n and remain stable until edge n+1.
- Throughput: one operation per cycle. Back-to-back opcode changes each produce their own result one cycle later.
- Reset mid-stream: the operation sampled at the same edge as reset is discarded. The first valid result appears one cycle after the first edge with `rst` = 0.
- Inputs held constant: the outputs stay constant; there are no glitches on the registered outputs.
- Outputs change only on the rising edge of `clk`.

## Test plan
1. **Reset.** Drive `rst`=1 for 2 cycles with A=8'hFF, B=8'hFF, Sel=0000 → `ALU_Out`=0 and `CarryOut`=0 throughout. After release, the next edge gives `ALU_Out`=8'hFE and `CarryOut`=1.
2. **Rotate left (0110).**
   - A=8'b1000_0001 → `ALU_Out`=8'b0000_0011.
   - A=8'hFF → 8'hFF.
   - A=8'h00 → 8'h00.
   - With B=8'h80, A=8'h81, `CarryOut`=1.
3. **Arithmetic wrap.**
   - Sel=0001, A=8'h05, B=8'h07 → 8'hFE.
   - Sel=0010, A=8'h10, B=8'h20 → 8'h00.
   - Sel=0011, A=8'd100, B=8'd7 → 8'd14.
   - Sel=0011, B=0 → 8'h00.
4. **Shift/rotate right.**
   - Sel=0101, A=8'h81 → 8'h40.
   - Sel=0111, A=8'h81 → 8'hC0.
   - Sel=0100, A=8'h81 → 8'h02.
5. **Logic and compare, with A=8'hF0, B=8'h3C.**
   - 1000 → 8'h30; 1001 → 8'hFC; 1010 → 8'hCC; 1011 → 8'h03; 1100 → 8'hCF; 1101 → 8'h33.
   - 1110 → 8'h01; 1111 → 8'h00.
   - With A=B=8'h3C: 1111 → 8'h01 and 1110 → 8'h00.
6. **Pipelining.** Change the opcode on every cycle through all 16 opcodes with random A/B → each result matches the reference model delayed by exactly one cycle. Assert `rst` for one cycle in the middle → outputs are zero on the following cycle, and the sequence resumes correctly afterwards.
